approx_booth_mult_seq: RTL
==========================

Name: approx_booth_mult_seq

Overview:
- Iterative, parametrised radix-4 Booth multiplier, signed WL x WL -> 2*WL.
- Per transaction, the caller picks exact or approximate Booth encoding and a runtime LSB-truncation count (VBL).
- Accumulates PPC partial products per cycle behind valid/ready handshakes on input and output.
- Sits in the datapath as the area-lean, runtime-configurable successor to the fully combinational approximate Booth multiplier.

Parameters:
- WL, 16: operand width; even, >= 4.
- PPC, 1: partial products accumulated per cycle; must divide WL/2.
- VBW, $clog2(2*WL+1): width of the vbl port (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept; high only in IDLE.
- x  in  WL  signed multiplier (Booth-recoded operand).
- y  in  WL  signed multiplicand.
- mode  in  1  0 = exact Booth, 1 = approximate Booth.
- vbl  in  VBW  number of LSBs forced to 0 in every shifted partial product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  2*WL  signed product.
- out_mode  out  1  mode used for this result.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, out=0, out_mode=0, accumulator=0, group counter=0. Reset mid-operation discards the transaction; no result is emitted.
- Group i (0..WL/2-1) is bits {x[2i+1], x[2i], x[2i-1]}, with x[-1]=0.
- Exact encoding, group -> pp: 000:0, 001:+y, 010:+y, 011:+2y, 100:-2y, 101:-y, 110:-y, 111:0.
- Approximate encoding, group -> pp: 000:0, 001:+y, 010:+y, 011:+y, 100:+2y, 101:-2y, 110:-y, 111:0.
- pp is sign-extended to 2*WL bits, then shifted left by 2i.
- After shifting, bits [vbl-1:0] of pp are zeroed. If vbl >= 2*WL, every pp is 0 and the result is 0.
- Sum is modulo 2^(2*WL); no saturation.
- FSM states: IDLE, BUSY, DONE.
- IDLE: on in_valid at an edge, capture x, y, mode and vbl, clear the accumulator and counter, then go to BUSY. Input changes after capture have no effect.
- BUSY: each edge adds pp for groups cnt..cnt+PPC-1 and advances cnt by PPC. On the edge that adds the last group, the final sum is registered into out, out_mode is set, out_valid=1, and the state goes to DONE.
- Busy time is N = WL/(2*PPC) edges.
- Latency: accept at edge k gives out_valid high after edge k+N.
- DONE: hold out and out_valid stable while out_ready=0. On out_ready=1 at an edge, out_valid goes 0 and the state returns to IDLE.
- out keeps its last value after the handshake.
- in_ready=0 in BUSY and DONE. in_valid is ignored there; there is no overlap of transactions.
- Peak throughput: one result per N+2 cycles.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Package approx_booth_pkg holds:
  - pp-select enum: PP_ZERO, PP_POS1, PP_POS2, PP_NEG1, PP_NEG2.
  - mode constants: MODE_EXACT=0, MODE_APPROX=1.
  - FSM state enum.
  - function booth_sel(group, mode) returning the enum.
- One sub-module, booth_pp_gen: combinational. Takes a group, mode, y, shift index and vbl; outputs the 2*WL-bit masked, shifted pp. Instantiate it PPC times.

Test Plan:
All cases use WL=8, PPC=1 (N=4) unless stated.
- Exact basic: x=3, y=5, mode=0, vbl=0 -> out=15 (0x000F) after 4 edges; in_ready low during BUSY and DONE.
- Approx divergence: x=2, y=5 -> mode=0 gives 10 (0x000A); mode=1 gives 30 (0x001E); out_mode matches.
- Signed corner: x=-128, y=-128 -> mode=0 gives 16384 (0x4000); mode=1 gives 0xC000.
- Truncation: x=3, y=5, mode=0, vbl=1 -> 14 (0x000E). Same operands with vbl=16 -> 0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> out and out_valid stable, in_valid ignored. Raise out_ready -> next cycle IDLE, in_ready=1.
- Reset mid-BUSY: assert rst 2 edges after accept -> next cycle out_valid=0, out=0, in_ready=1; a new transaction x=3, y=5 then yields 15.
- Repeat the first three cases with PPC=2 (N=2) and with PPC=4 (N=1): same results, latency N.

Source files
------------

// File: rtl/approx_booth_pkg.sv
// Shared types and Booth recoding tables for the sequential approximate Booth multiplier.
// Holds no logic; booth_sel maps a 3-bit recoding group to a partial-product selection.
package approx_booth_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_POS1,
        PP_POS2,
        PP_NEG1,
        PP_NEG2
    } pp_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    function automatic pp_sel_t booth_sel(input logic [2:0] group, input logic mode);
        pp_sel_t sel;
        sel = PP_ZERO;
        if (mode == MODE_EXACT) begin
            case (group)
                3'b001, 3'b010: sel = PP_POS1;
                3'b011:         sel = PP_POS2;
                3'b100:         sel = PP_NEG2;
                3'b101, 3'b110: sel = PP_NEG1;
                default:        sel = PP_ZERO;
            endcase
        end else begin
            // Approximate table trades sign handling on 011/100/101 for a simpler selector
            case (group)
                3'b001, 3'b010, 3'b011: sel = PP_POS1;
                3'b100:                 sel = PP_POS2;
                3'b101:                 sel = PP_NEG2;
                3'b110:                 sel = PP_NEG1;
                default:                sel = PP_ZERO;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth partial product: select, sign-extend, shift by 2*idx and clear the low vbl bits.
// Purely combinational, zero latency, no flow control.
module booth_pp_gen
    import approx_booth_pkg::*;
#(
    parameter int WL  = 16,
    parameter int VBW = $clog2(2*WL+1),
    parameter int IW  = $clog2(WL/2+1)
) (
    input  logic [2:0]      group_i,
    input  logic            mode_i,
    input  logic [WL-1:0]   y_i,
    input  logic [IW-1:0]   idx_i,
    input  logic [VBW-1:0]  vbl_i,
    output logic [2*WL-1:0] pp_o
);

    logic [2*WL-1:0] ys;
    logic [2*WL-1:0] base;

    always_comb begin
        ys   = {{WL{y_i[WL-1]}}, y_i};
        base = '0;
        case (booth_sel(group_i, mode_i))
            PP_POS1: base = ys;
            PP_POS2: base = ys << 1;
            PP_NEG1: base = -ys;
            PP_NEG2: base = -(ys << 1);
            default: base = '0;
        endcase
        // A shift of vbl >= 2*WL leaves an all-zero mask, so the whole pp vanishes
        pp_o = (base << {idx_i, 1'b0}) & ({(2*WL){1'b1}} << vbl_i);
    end

endmodule

// File: rtl/approx_booth_mult_seq.sv
// Iterative radix-4 Booth multiplier (exact/approximate, runtime LSB truncation), PPC groups per cycle.
// Result valid WL/(2*PPC) edges after accept; holds result in DONE until out_ready, in_ready only in IDLE.
module approx_booth_mult_seq
    import approx_booth_pkg::*;
#(
    parameter int WL  = 16,
    parameter int PPC = 1,
    parameter int VBW = $clog2(2*WL+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WL-1:0]   x,
    input  logic [WL-1:0]   y,
    input  logic            mode,
    input  logic [VBW-1:0]  vbl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*WL-1:0] out,
    output logic            out_mode
);

    localparam int NG = WL / 2;
    localparam int CW = $clog2(NG + 1);
    localparam logic [CW-1:0] PPC_C  = CW'(PPC);
    localparam logic [CW-1:0] LAST_C = CW'(NG - PPC);

    state_t          state_q, state_d;
    logic [WL:0]     xe_q, xe_d;
    logic [WL-1:0]   y_q, y_d;
    logic            mode_q, mode_d;
    logic [VBW-1:0]  vbl_q, vbl_d;
    logic [2*WL-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*WL-1:0] out_q, out_d;
    logic            out_mode_q, out_mode_d;

    logic [2*WL-1:0] pp_w [PPC];
    logic [2*WL-1:0] pp_sum;

    // xe_q carries x with the implicit x[-1]=0 appended, so group i is xe_q[2i+2:2i]
    for (genvar j = 0; j < PPC; j++) begin : g_pp
        logic [CW-1:0] gidx;
        logic [2:0]    grp;

        assign gidx = cnt_q + CW'(j);
        assign grp  = 3'(xe_q >> {gidx, 1'b0});

        booth_pp_gen #(
            .WL  (WL),
            .VBW (VBW),
            .IW  (CW)
        ) u_pp_gen (
            .group_i (grp),
            .mode_i  (mode_q),
            .y_i     (y_q),
            .idx_i   (gidx),
            .vbl_i   (vbl_q),
            .pp_o    (pp_w[j])
        );
    end

    always_comb begin
        pp_sum = acc_q;
        for (int j = 0; j < PPC; j++) begin
            pp_sum = pp_sum + pp_w[j];
        end
    end

    always_comb begin
        state_d    = state_q;
        xe_d       = xe_q;
        y_d        = y_q;
        mode_d     = mode_q;
        vbl_d      = vbl_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        out_mode_d = out_mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    xe_d    = {x, 1'b0};
                    y_d     = y;
                    mode_d  = mode;
                    vbl_d   = vbl;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d = pp_sum;
                cnt_d = cnt_q + PPC_C;
                if (cnt_q == LAST_C) begin
                    out_d      = pp_sum;
                    out_mode_d = mode_q;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            xe_q       <= '0;
            y_q        <= '0;
            mode_q     <= 1'b0;
            vbl_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            out_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            xe_q       <= xe_d;
            y_q        <= y_d;
            mode_q     <= mode_d;
            vbl_q      <= vbl_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            out_mode_q <= out_mode_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign out_mode  = out_mode_q;

endmodule
